// File: rtl/muladdsub_pkg.sv
// rtl/muladdsub_pkg.sv - shared width helpers and saturation limits for muladdsub_acc
//
// clog2       : ceiling log2 used to size the product-sum width
// sum_width   : AW+BW+clog2(NPROD), the width that holds any sum of NPROD products
// sat_max/min : signed clamp limits for an OUTW-bit result, returned in LIMW bits
//               (callers slice the low OUTW bits; OUTW must not exceed LIMW)
package muladdsub_pkg;

    localparam int LIMW = 128;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int sum_width(input int aw, input int bw, input int nprod);
        return aw + bw + clog2(nprod);
    endfunction

    // 2^(outw-1)-1: outw-1 ones in the low bits
    function automatic logic signed [LIMW-1:0] sat_max(input int outw);
        logic signed [LIMW-1:0] r;
        r = '1;
        r = r >> (LIMW - outw + 1);
        return r;
    endfunction

    // -2^(outw-1): ones from bit outw-1 upward
    function automatic logic signed [LIMW-1:0] sat_min(input int outw);
        logic signed [LIMW-1:0] r;
        r = '1;
        r = r << (outw - 1);
        return r;
    endfunction

endpackage

// File: rtl/muladdsub_acc_if.sv
// rtl/muladdsub_acc_if.sv - datapath bundle between sample alignment and muladdsub_acc
//
// master : upstream driver (CE, IN_VALID, ADDNSUB, A, B, ACC_MODE, ACC_CLR out; results in)
// slave  : muladdsub_acc (operands in; SUM, OUT_VALID, OVF out)
interface muladdsub_acc_if #(
    parameter int AW    = 18,
    parameter int BW    = 18,
    parameter int NPROD = 2,
    parameter int OUTW  = 44
);
    logic                   CE;
    logic                   IN_VALID;
    logic [NPROD-1:0]       ADDNSUB;
    logic [NPROD*AW-1:0]    A;
    logic [NPROD*BW-1:0]    B;
    logic                   ACC_MODE;
    logic                   ACC_CLR;
    logic signed [OUTW-1:0] SUM;
    logic                   OUT_VALID;
    logic                   OVF;

    modport master (
        output CE, IN_VALID, ADDNSUB, A, B, ACC_MODE, ACC_CLR,
        input  SUM, OUT_VALID, OVF
    );

    modport slave (
        input  CE, IN_VALID, ADDNSUB, A, B, ACC_MODE, ACC_CLR,
        output SUM, OUT_VALID, OVF
    );
endinterface

// File: rtl/muladdsub_sat.sv
// rtl/muladdsub_sat.sv - combinational signed add with clamp to the OUTW range
//
// base   : OUTW-bit signed accumulator value
// addend : SUMW-bit signed product sum (SUMW <= OUTW)
// result : base+addend clamped to [-2^(OUTW-1), 2^(OUTW-1)-1]
// ovf    : 1 when the clamp was applied
module muladdsub_sat
    import muladdsub_pkg::*;
#(
    parameter int OUTW = 44,
    parameter int SUMW = 37
) (
    input  logic signed [OUTW-1:0] base,
    input  logic signed [SUMW-1:0] addend,
    output logic signed [OUTW-1:0] result,
    output logic                   ovf
);
    localparam logic signed [LIMW-1:0] MAX_W = sat_max(OUTW);
    localparam logic signed [LIMW-1:0] MIN_W = sat_min(OUTW);
    localparam logic signed [OUTW-1:0] MAX_V = MAX_W[OUTW-1:0];
    localparam logic signed [OUTW-1:0] MIN_V = MIN_W[OUTW-1:0];

    // One guard bit is enough because |addend| never exceeds the OUTW range.
    logic signed [OUTW:0] wide;

    always_comb begin
        wide = (OUTW+1)'(base) + (OUTW+1)'(addend);
        ovf  = wide[OUTW] != wide[OUTW-1];
        if (!ovf) begin
            result = wide[OUTW-1:0];
        end else if (wide[OUTW]) begin
            result = MIN_V;
        end else begin
            result = MAX_V;
        end
    end
endmodule

// File: rtl/muladdsub_acc.sv
// rtl/muladdsub_acc.sv - three-stage signed sum of NPROD products with saturating accumulate
//
// CLK0  : clock, rising edge
// RSTN0 : asynchronous active-low reset
// bus   : muladdsub_acc_if slave (CE stall enable, operand beat in, SUM/OUT_VALID/OVF out)
// Stage 1 registers the beat, stage 2 forms the signed +/- products,
// stage 3 sums them and either overwrites or saturating-accumulates SUM.
module muladdsub_acc
    import muladdsub_pkg::*;
#(
    parameter int AW    = 18,
    parameter int BW    = 18,
    parameter int NPROD = 2,
    parameter int OUTW  = 44
) (
    input  logic           CLK0,
    input  logic           RSTN0,
    muladdsub_acc_if.slave bus
);
    localparam int PW   = AW + BW;
    localparam int SUMW = sum_width(AW, BW, NPROD);

    generate
        if (OUTW < SUMW) begin : g_outw_too_small
            $error("muladdsub_acc: OUTW must be >= AW+BW+clog2(NPROD)");
        end
        if (OUTW > LIMW) begin : g_outw_too_large
            $error("muladdsub_acc: OUTW exceeds saturation limit width");
        end
    endgenerate

    // stage 1
    logic [NPROD*AW-1:0] a1_q, a1_d;
    logic [NPROD*BW-1:0] b1_q, b1_d;
    logic [NPROD-1:0]    ans1_q, ans1_d;
    logic                v1_q, v1_d;
    logic                mode1_q, mode1_d;
    logic                clr1_q, clr1_d;

    // stage 2
    logic signed [PW-1:0] prod_sel [NPROD];
    logic signed [PW-1:0] p2_q [NPROD];
    logic signed [PW-1:0] p2_d [NPROD];
    logic                 v2_q, v2_d;
    logic                 mode2_q, mode2_d;
    logic                 clr2_q, clr2_d;

    // stage 3
    logic signed [OUTW-1:0] sum_q, sum_d;
    logic                   out_valid_q, out_valid_d;
    logic                   ovf_q, ovf_d;

    logic signed [SUMW-1:0] s_sum;
    logic signed [OUTW-1:0] acc_base;
    logic signed [OUTW-1:0] sat_result;
    logic                   sat_ovf;

    always_comb begin
        a1_d    = a1_q;
        b1_d    = b1_q;
        ans1_d  = ans1_q;
        v1_d    = v1_q;
        mode1_d = mode1_q;
        clr1_d  = clr1_q;
        if (bus.CE) begin
            a1_d    = bus.A;
            b1_d    = bus.B;
            ans1_d  = bus.ADDNSUB;
            v1_d    = bus.IN_VALID;
            mode1_d = bus.ACC_MODE;
            clr1_d  = bus.ACC_CLR;
        end
    end

    // Product of two signed values fits AW+BW bits, and so does its negation.
    for (genvar i = 0; i < NPROD; i++) begin : g_lane
        logic signed [AW-1:0] a_l;
        logic signed [BW-1:0] b_l;
        logic signed [PW-1:0] prod;
        assign a_l         = a1_q[i*AW +: AW];
        assign b_l         = b1_q[i*BW +: BW];
        assign prod        = PW'(a_l) * PW'(b_l);
        assign prod_sel[i] = ans1_q[i] ? prod : -prod;
    end

    always_comb begin
        for (int i = 0; i < NPROD; i++) begin
            p2_d[i] = p2_q[i];
        end
        v2_d    = v2_q;
        mode2_d = mode2_q;
        clr2_d  = clr2_q;
        if (bus.CE) begin
            for (int i = 0; i < NPROD; i++) begin
                p2_d[i] = prod_sel[i];
            end
            v2_d    = v1_q;
            mode2_d = mode1_q;
            clr2_d  = clr1_q;
        end
    end

    always_comb begin
        s_sum = '0;
        for (int i = 0; i < NPROD; i++) begin
            s_sum = s_sum + SUMW'(p2_q[i]);
        end
    end

    assign acc_base = clr2_q ? '0 : sum_q;

    muladdsub_sat #(
        .OUTW (OUTW),
        .SUMW (SUMW)
    ) u_sat (
        .base   (acc_base),
        .addend (s_sum),
        .result (sat_result),
        .ovf    (sat_ovf)
    );

    // OVF is sticky; any ACC_CLR beat clears it, but a clamp on that same beat re-sets it.
    always_comb begin
        sum_d       = sum_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;
        if (bus.CE) begin
            out_valid_d = v2_q;
            if (v2_q) begin
                if (mode2_q) begin
                    sum_d = sat_result;
                    ovf_d = (ovf_q & ~clr2_q) | sat_ovf;
                end else begin
                    sum_d = OUTW'(s_sum);
                    if (clr2_q) begin
                        ovf_d = 1'b0;
                    end
                end
            end else if (clr2_q) begin
                sum_d = '0;
                ovf_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK0 or negedge RSTN0) begin
        if (!RSTN0) begin
            a1_q        <= '0;
            b1_q        <= '0;
            ans1_q      <= '0;
            v1_q        <= 1'b0;
            mode1_q     <= 1'b0;
            clr1_q      <= 1'b0;
            for (int i = 0; i < NPROD; i++) begin
                p2_q[i] <= '0;
            end
            v2_q        <= 1'b0;
            mode2_q     <= 1'b0;
            clr2_q      <= 1'b0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            a1_q        <= a1_d;
            b1_q        <= b1_d;
            ans1_q      <= ans1_d;
            v1_q        <= v1_d;
            mode1_q     <= mode1_d;
            clr1_q      <= clr1_d;
            for (int i = 0; i < NPROD; i++) begin
                p2_q[i] <= p2_d[i];
            end
            v2_q        <= v2_d;
            mode2_q     <= mode2_d;
            clr2_q      <= clr2_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.SUM       = sum_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.OVF       = ovf_q;
endmodule

// File: tb/tb_muladdsub_acc.sv
// tb/tb_muladdsub_acc.sv - bench for muladdsub_acc at OUTW=44 and OUTW=37
module tb_muladdsub_acc;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic              ce       = 1'b1;
    logic              in_valid = 1'b0;
    logic [1:0]        ans      = 2'b11;
    logic signed [17:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
    logic              mode = 1'b0;
    logic              clr  = 1'b0;

    muladdsub_acc_if #(.AW(18), .BW(18), .NPROD(2), .OUTW(44)) if44 ();
    muladdsub_acc_if #(.AW(18), .BW(18), .NPROD(2), .OUTW(37)) if37 ();

    assign if44.CE = ce;        assign if37.CE = ce;
    assign if44.IN_VALID = in_valid; assign if37.IN_VALID = in_valid;
    assign if44.ADDNSUB = ans;  assign if37.ADDNSUB = ans;
    assign if44.A = {a1, a0};   assign if37.A = {a1, a0};
    assign if44.B = {b1, b0};   assign if37.B = {b1, b0};
    assign if44.ACC_MODE = mode; assign if37.ACC_MODE = mode;
    assign if44.ACC_CLR = clr;  assign if37.ACC_CLR = clr;

    muladdsub_acc #(.AW(18), .BW(18), .NPROD(2), .OUTW(44)) dut44 (
        .CLK0 (clk), .RSTN0 (rstn), .bus (if44)
    );
    muladdsub_acc #(.AW(18), .BW(18), .NPROD(2), .OUTW(37)) dut37 (
        .CLK0 (clk), .RSTN0 (rstn), .bus (if37)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit       v;
        bit [1:0] ans;
        longint   a0, a1, b0, b1;
        bit       mode;
        bit       clr;
    } beat_t;

    beat_t  pipe[$];
    longint m_sum[2];
    bit     m_ovf[2];
    bit     m_ov[2];
    int     outw[2] = '{44, 37};

    function automatic beat_t idle_beat();
        beat_t b;
        b.v = 0; b.ans = 2'b00; b.a0 = 0; b.a1 = 0; b.b0 = 0; b.b1 = 0;
        b.mode = 0; b.clr = 0;
        return b;
    endfunction

    function automatic longint beat_sum(input beat_t b);
        longint p0, p1;
        p0 = b.a0 * b.b0;
        p1 = b.a1 * b.b1;
        return (b.ans[0] ? p0 : -p0) + (b.ans[1] ? p1 : -p1);
    endfunction

    task automatic model_apply(input beat_t b);
        longint s, hi, lo, t;
        s = beat_sum(b);
        for (int k = 0; k < 2; k++) begin
            hi = (longint'(1) << (outw[k] - 1)) - 1;
            lo = -hi - 1;
            m_ov[k] = b.v;
            if (b.v && !b.mode) begin
                m_sum[k] = s;
                if (b.clr) m_ovf[k] = 0;
            end else if (b.v) begin
                t = (b.clr ? 0 : m_sum[k]) + s;
                if (b.clr) m_ovf[k] = 0;
                if (t > hi) begin
                    t = hi; m_ovf[k] = 1;
                end else if (t < lo) begin
                    t = lo; m_ovf[k] = 1;
                end
                m_sum[k] = t;
            end else if (b.clr) begin
                m_sum[k] = 0;
                m_ovf[k] = 0;
            end
        end
    endtask

    // A beat taken on one CE edge becomes visible two CE edges later.
    always @(posedge clk or negedge rstn) begin
        beat_t cur;
        if (!rstn) begin
            pipe.delete();
            pipe.push_back(idle_beat());
            pipe.push_back(idle_beat());
            for (int k = 0; k < 2; k++) begin
                m_sum[k] = 0; m_ovf[k] = 0; m_ov[k] = 0;
            end
        end else if (ce) begin
            cur.v = in_valid; cur.ans = ans;
            cur.a0 = a0; cur.a1 = a1; cur.b0 = b0; cur.b1 = b1;
            cur.mode = mode; cur.clr = clr;
            pipe.push_back(cur);
            model_apply(pipe.pop_front());
        end
    end

    bit run_cmp = 0;
    always @(negedge clk) begin
        if (run_cmp) begin
            chk("cmp44_sum", longint'(if44.SUM), m_sum[0]);
            chk("cmp44_ov",  longint'(if44.OUT_VALID), longint'(m_ov[0]));
            chk("cmp44_ovf", longint'(if44.OVF), longint'(m_ovf[0]));
            chk("cmp37_sum", longint'(if37.SUM), m_sum[1]);
            chk("cmp37_ov",  longint'(if37.OUT_VALID), longint'(m_ov[1]));
            chk("cmp37_ovf", longint'(if37.OVF), longint'(m_ovf[1]));
        end
    end

    int nvalid = 0;
    always @(posedge clk) begin
        if (if44.OUT_VALID && ce) nvalid++;
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input bit [1:0] s, input int x0, input int x1,
                         input int y0, input int y1, input bit m, input bit c);
        @(negedge clk);
        ce = 1'b1; in_valid = v; ans = s;
        a0 = 18'(x0); a1 = 18'(x1); b0 = 18'(y0); b1 = 18'(y1);
        mode = m; clr = c;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 2'b11, 0, 0, 0, 0, 0, 0);
    endtask

    localparam int NEG = -131072;
    localparam longint SAT37 = 64'd68719476735;

    initial begin
        // reset state
        rstn = 1'b0;
        @(posedge clk);
        run_cmp = 1;
        idle(2);
        chk("rst_sum44", longint'(if44.SUM), 0);
        chk("rst_ov44", longint'(if44.OUT_VALID), 0);
        chk("rst_ovf37", longint'(if37.OVF), 0);
        rstn = 1'b1;
        idle(2);

        // basic sum: 2*3 + 3*3
        drive(1, 2'b11, 2, 3, 3, 3, 0, 0);
        idle(1); chk("basic_ov_early1", longint'(if44.OUT_VALID), 0);
        idle(1); chk("basic_ov_early2", longint'(if44.OUT_VALID), 0);
        idle(1);
        chk("basic_sum", longint'(if44.SUM), 15);
        chk("basic_ov", longint'(if44.OUT_VALID), 1);
        chk("basic_ovf", longint'(if44.OVF), 0);
        idle(1); chk("basic_ov_pulse", longint'(if44.OUT_VALID), 0);

        // per-lane subtract
        drive(1, 2'b01, 2, 3, 3, 3, 0, 0);
        drive(1, 2'b10, NEG, NEG, NEG, 1, 0, 0);
        idle(2); chk("sub_sum", longint'(if44.SUM), -3);
        idle(1); chk("sub_big44", longint'(if44.SUM), -64'sd17180000256);
        chk("sub_big37", longint'(if37.SUM), -64'sd17180000256);
        idle(2);

        // accumulate 15 four times, then non-valid clear
        drive(1, 2'b11, 2, 3, 3, 3, 1, 1);
        drive(1, 2'b11, 2, 3, 3, 3, 1, 0);
        drive(1, 2'b11, 2, 3, 3, 3, 1, 0);
        drive(1, 2'b11, 2, 3, 3, 3, 1, 0);
        chk("acc_1", longint'(if44.SUM), 15);
        idle(1); chk("acc_2", longint'(if44.SUM), 30);
        idle(1); chk("acc_3", longint'(if44.SUM), 45);
        idle(1); chk("acc_4", longint'(if44.SUM), 60);
        drive(0, 2'b11, 0, 0, 0, 0, 0, 1);
        idle(3); chk("acc_clr", longint'(if44.SUM), 0);

        // saturation on the OUTW=37 instance
        drive(1, 2'b11, NEG, NEG, NEG, NEG, 1, 1);
        drive(1, 2'b11, NEG, NEG, NEG, NEG, 1, 0);
        drive(1, 2'b11, NEG, NEG, NEG, NEG, 1, 0);
        drive(1, 2'b11, NEG, NEG, NEG, NEG, 1, 0);
        chk("sat_first", longint'(if37.SUM), 64'd34359738368);
        chk("sat_first_ovf", longint'(if37.OVF), 0);
        idle(1); chk("sat_clamp", longint'(if37.SUM), SAT37);
        chk("sat_ovf", longint'(if37.OVF), 1);
        chk("sat_no_clamp44", longint'(if44.SUM), 64'd68719476736);
        idle(2); chk("sat_hold", longint'(if37.SUM), SAT37);
        // plain beat overwrites, accumulate adds, OVF stays until a clear
        drive(1, 2'b11, 2, 3, 3, 3, 0, 0);
        drive(1, 2'b11, 2, 3, 3, 3, 1, 0);
        drive(0, 2'b11, 0, 0, 0, 0, 0, 1);
        idle(1); chk("mix_plain", longint'(if37.SUM), 15);
        chk("mix_ovf_sticky", longint'(if37.OVF), 1);
        idle(1); chk("mix_acc", longint'(if37.SUM), 30);
        idle(1); chk("mix_clr_sum", longint'(if37.SUM), 0);
        chk("mix_clr_ovf", longint'(if37.OVF), 0);
        idle(2);

        // 100 incrementing beats with a 5-cycle stall in the middle
        nvalid = 0;
        for (int n = 0; n < 100; n++) begin
            if (n == 50) begin
                repeat (5) begin
                    @(negedge clk);
                    ce = 1'b0; in_valid = 1'b1; a0 = 18'(1234); mode = 1'b1;
                end
            end
            drive(1, 2'b01, n, n + 1, 3, -2, 0, 0);
        end
        idle(4);
        chk("stream_count", longint'(nvalid), 100);
        chk("stream_last", longint'(if44.SUM), 497);

        // asynchronous reset with beats in flight
        for (int n = 0; n < 6; n++) begin
            drive(1, 2'b11, NEG, NEG, NEG, NEG, 1, n == 0);
        end
        chk("pre_rst_ovf37", longint'(if37.OVF), 1);
        @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        chk("arst_sum44", longint'(if44.SUM), 0);
        chk("arst_ov44", longint'(if44.OUT_VALID), 0);
        chk("arst_sum37", longint'(if37.SUM), 0);
        chk("arst_ovf37", longint'(if37.OVF), 0);
        idle(2);
        @(negedge clk);
        rstn = 1'b1;
        for (int n = 0; n < 5; n++) begin
            idle(1);
            chk("post_rst_ov", longint'(if44.OUT_VALID), 0);
        end

        run_cmp = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/muladdsub_acc.md
Name: muladdsub_acc

Overview:
Parametrised successor to the two-product muladdsub datapath element. It computes a signed sum of NPROD products, each with its own add/subtract select, and adds an optional saturating accumulate mode. It replaces the per-stage clock enables with a single stall enable and a valid pipeline. It sits in the datapath between sample-alignment logic and downstream filter/correlator stages.

Parameters:
AW, 18, signed width of each A operand
BW, 18, signed width of each B operand
NPROD, 2, number of products summed (>=1)
OUTW, 44, signed width of SUM/accumulator; must be >= AW+BW+clog2(NPROD) (elaboration error otherwise)

Ports:
CLK0  in  1  clock, all registers rising-edge
RSTN0  in  1  asynchronous active-low reset
CE  in  1  pipeline advance enable; 0 = every stage holds
IN_VALID  in  1  input beat valid
ADDNSUB  in  NPROD  per-product sign: bit i 1 = add product i, 0 = subtract
A  in  NPROD*AW  packed signed operands, lane i at [i*AW +: AW]
B  in  NPROD*BW  packed signed operands, lane i at [i*BW +: BW]
ACC_MODE  in  1  1 = accumulate, 0 = plain sum
ACC_CLR  in  1  clear accumulator (travels with its beat)
SUM  out  OUTW  signed result / accumulator
OUT_VALID  out  1  SUM updated by a valid beat this stage
OVF  out  1  sticky saturation flag

Behaviour:
- Reset (RSTN0=0, any time, incl. mid-operation): all stage valids=0, SUM=0, OUT_VALID=0, OVF=0, accumulator=0; in-flight beats discarded.
- All state advances only when CE=1; when CE=0 every register incl. SUM/OUT_VALID/OVF holds. Downstream samples SUM when OUT_VALID&CE.
- Stage 1 (input reg): capture A, B, ADDNSUB, IN_VALID, ACC_MODE, ACC_CLR.
- Stage 2 (multiply): p_i = A_i*B_i signed, AW+BW bits; p_i negated if ADDNSUB_i=0. AW+BW bits suffice for both signs, so there is no overflow here.
- Stage 3 (sum/accumulate): s = sum of p_i, sign-extended to AW+BW+clog2(NPROD).
  - If the beat is valid and ACC_MODE=0: SUM <= sign-extend(s). This never saturates.
  - If the beat is valid and ACC_MODE=1: base = 0 if ACC_CLR else SUM. SUM <= sat(base + s), clamped to [-2^(OUTW-1), 2^(OUTW-1)-1]. On a clamp, OVF <= 1.
  - If the beat is not valid but ACC_CLR=1: SUM <= 0, OVF <= 0.
  - If the beat is not valid and ACC_CLR=0: SUM holds.
- OVF clears only on reset or any ACC_CLR beat (valid or not). A valid ACC_CLR beat that itself saturates leaves OVF=1.
- OUT_VALID <= stage-2 valid (registered with SUM).
- Latency: IN_VALID beat at CE edge k appears on SUM/OUT_VALID after edge k+2 (3 CE edges through stages 1-3). Throughput: 1 beat per CE cycle, with no bubbles inserted.
- Mixing ACC_MODE per beat is legal. A plain-sum beat overwrites SUM, and a later accumulate beat without CLR adds to it.

Decomposition:
- Package muladdsub_pkg holds the clog2 function, a sum-width helper (AW+BW+clog2(NPROD)), and the saturation limit constants as functions of OUTW.
- One sub-module, muladdsub_sat: combinational signed add of OUTW + SUMW inputs with clamp and overflow output. It is used in stage 3.
- The product/negate lanes are a generate loop inside the top.

Test Plan:
- Basic sum (defaults): A=(2,3), B=(3,3), ADDNSUB=2'b11, ACC_MODE=0, one valid beat -> SUM=15, OUT_VALID pulses 3 CE edges later, OVF=0.
- Per-lane subtract: same operands, ADDNSUB=2'b01 (lane0 add, lane1 sub) -> SUM=-3. With A=(-131072,-131072), B=(-131072,1), ADDNSUB=2'b10 -> SUM = -2^34 - 131072.
- Accumulate: 4 consecutive valid beats of sum 15, ACC_MODE=1, ACC_CLR on the first -> SUM=15, 30, 45, 60. A non-valid ACC_CLR -> SUM=0.
- Stall: CE=0 for 5 cycles mid-stream of 100 incrementing beats -> SUM/OUT_VALID frozen, no beat lost or duplicated, and the output sequence matches the reference model.
- Saturation (OUTW=37): A=B=(-131072,-131072), ACC_MODE=1, CLR on beat1 -> SUM=2^35, then 68719476735 (clamped), OVF=1. OVF stays set through further beats and clears on the next ACC_CLR.
- Reset mid-operation: deassert RSTN0 asynchronously (not on a clock edge) with 3 beats in flight -> SUM=0, OUT_VALID=0, OVF=0 immediately. After release, no stale beat emerges.
